// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers: side selection,
// pointer width and the Gray-code helpers used on both clock domains.
package fifo_pkg;

    localparam int MODE_WR   = 0;
    localparam int MODE_RD   = 1;

    // Widest pointer the helpers below handle; callers zero-extend into it.
    localparam int MAX_PTR_W = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int PTR_W(input int aw);
        return aw + 1;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin_to_gray(input logic [MAX_PTR_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Full when the local Gray pointer equals the remote one with its two
    // MSBs inverted, i.e. the binary pointers differ by exactly one depth.
    function automatic logic full_match(input logic [MAX_PTR_W-1:0] gray,
                                        input logic [MAX_PTR_W-1:0] remote,
                                        input int                   pw);
        logic [MAX_PTR_W-1:0] mask;
        mask = MAX_PTR_W'(3) << (pw - 2);
        return gray == (remote ^ mask);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder: MSB passes through, each lower bit is
// the XOR of all Gray bits from the MSB down to itself.
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One side of an async FIFO: owns the local binary/Gray pointer, brings the
// remote Gray pointer into this clock domain and derives full (write side) or
// empty (read side), an almost flag and the fill level, all registered.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int MODE          = 0,
    parameter int ALMOST_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_req,
    input  logic [ADDR_WIDTH:0]   remote_gray_ptr,
    output logic                  inc_ack,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   bin_ptr,
    output logic [ADDR_WIDTH:0]   gray_ptr,
    output logic                  flag,
    output logic                  almost_flag,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int           PW       = PTR_W(ADDR_WIDTH);
    localparam int           DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] HI_MARK = PW'(DEPTH - ALMOST_THRESH);
    localparam logic [PW-1:0] LO_MARK = PW'(ALMOST_THRESH);
    // The read side comes out of reset empty; the write side not full.
    localparam logic         RST_FLAG = (MODE == MODE_RD);

    logic [PW-1:0] sync_p [SYNC_STAGES];
    logic [PW-1:0] rg;
    logic [PW-1:0] rb;
    logic          acc;
    logic [PW-1:0] bin_nxt;
    logic [PW-1:0] gray_nxt;
    logic [PW-1:0] level_nxt;
    logic          flag_nxt;
    logic          almost_nxt;

    // Remote Gray pointer crosses into this domain through a plain flop chain;
    // Gray coding guarantees any sampled value is either the old or new pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= remote_gray_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign rg = sync_p[SYNC_STAGES-1];

    gray_to_bin #(
        .WIDTH (PW)
    ) u_rg_to_bin (
        .gray (rg),
        .bin  (rb)
    );

    // While the flag is up requests are dropped and the pointer holds.
    assign acc      = inc_req & ~flag;
    assign inc_ack  = acc;
    assign bin_nxt  = bin_ptr + PW'(acc);
    assign gray_nxt = PW'(bin_to_gray(MAX_PTR_W'(bin_nxt)));
    assign addr     = bin_ptr[ADDR_WIDTH-1:0];

    // Flags are taken from the next pointer so a local accept is reflected on
    // the same edge; the remote side only ever lags, which keeps them pessimistic.
    if (MODE == MODE_WR) begin : g_wr
        assign flag_nxt   = full_match(MAX_PTR_W'(gray_nxt), MAX_PTR_W'(rg), PW);
        assign level_nxt  = bin_nxt - rb;
        assign almost_nxt = (level_nxt >= HI_MARK);
    end else begin : g_rd
        assign flag_nxt   = (gray_nxt == rg);
        assign level_nxt  = rb - bin_nxt;
        assign almost_nxt = (level_nxt <= LO_MARK);
    end

    // Pointer, flag and level registers; reset lands on an idle FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_ptr     <= '0;
            gray_ptr    <= '0;
            level       <= '0;
            flag        <= RST_FLAG;
            almost_flag <= RST_FLAG;
        end else begin
            bin_ptr     <= bin_nxt;
            gray_ptr    <= gray_nxt;
            level       <= level_nxt;
            flag        <= flag_nxt;
            almost_flag <= almost_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: a write-side and a read-side instance driven
// together, with a cycle model pushing expected results into a scoreboard.
`timescale 1ns/1ps
module tb_fifo_ptr_ctrl;

    localparam int AW    = 3;
    localparam int PW    = 4;
    localparam int DEPTH = 8;
    localparam int SS    = 2;
    localparam int AT    = 2;
    localparam int PMASK = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req, rd_req;
    logic [PW-1:0] wr_rgray, rd_rgray;
    logic          wr_ack, rd_ack;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [PW-1:0] wr_bin, rd_bin, wr_gray, rd_gray, wr_level, rd_level;
    logic          wr_flag, rd_flag, wr_almost, rd_almost;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .MODE(0), .ALMOST_THRESH(AT)) u_wr (
        .clk(clk), .rst(rst), .inc_req(wr_req), .remote_gray_ptr(wr_rgray),
        .inc_ack(wr_ack), .addr(wr_addr), .bin_ptr(wr_bin), .gray_ptr(wr_gray),
        .flag(wr_flag), .almost_flag(wr_almost), .level(wr_level));

    fifo_ptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .MODE(1), .ALMOST_THRESH(AT)) u_rd (
        .clk(clk), .rst(rst), .inc_req(rd_req), .remote_gray_ptr(rd_rgray),
        .inc_ack(rd_ack), .addr(rd_addr), .bin_ptr(rd_bin), .gray_ptr(rd_gray),
        .flag(rd_flag), .almost_flag(rd_almost), .level(rd_level));

    typedef struct {
        int bin;
        int gray;
        int addr;
        int flag;
        int almost;
        int level;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state per side (0 = write, 1 = read); s0/s1 are the remote binary
    // pointer as seen through the two synchroniser stages.
    int m_bin[2], m_s0[2], m_s1[2], m_flag[2], m_level[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int g(input int b);
        return (b ^ (b >> 1)) & PMASK;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_bin[s] = 0; m_s0[s] = 0; m_s1[s] = 0; m_level[s] = 0;
        end
        m_flag[0] = 0;
        m_flag[1] = 1;
    endtask

    // Occupancy-based model: full means level == depth, empty means level == 0.
    task automatic model_step(input int side, input logic req, input int rbin, output exp_t e);
        int acc;
        int rb;
        acc = (req && m_flag[side] == 0) ? 1 : 0;
        rb  = m_s1[side];
        m_bin[side] = (m_bin[side] + acc) & PMASK;
        if (side == 0) begin
            m_level[side] = (m_bin[side] - rb) & PMASK;
            m_flag[side]  = (m_level[side] == DEPTH) ? 1 : 0;
            e.almost      = (m_level[side] >= DEPTH - AT) ? 1 : 0;
        end else begin
            m_level[side] = (rb - m_bin[side]) & PMASK;
            m_flag[side]  = (m_level[side] == 0) ? 1 : 0;
            e.almost      = (m_level[side] <= AT) ? 1 : 0;
        end
        m_s1[side] = m_s0[side];
        m_s0[side] = rbin & PMASK;
        e.bin   = m_bin[side];
        e.gray  = g(m_bin[side]);
        e.addr  = m_bin[side] & (DEPTH - 1);
        e.flag  = m_flag[side];
        e.level = m_level[side];
    endtask

    task automatic compare_side(input int side);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            if (side == 0) begin
                check("wr_bin",    32'(wr_bin),    e.bin);
                check("wr_gray",   32'(wr_gray),   e.gray);
                check("wr_addr",   32'(wr_addr),   e.addr);
                check("wr_flag",   32'(wr_flag),   e.flag);
                check("wr_almost", 32'(wr_almost), e.almost);
                check("wr_level",  32'(wr_level),  e.level);
            end else begin
                check("rd_bin",    32'(rd_bin),    e.bin);
                check("rd_gray",   32'(rd_gray),   e.gray);
                check("rd_addr",   32'(rd_addr),   e.addr);
                check("rd_flag",   32'(rd_flag),   e.flag);
                check("rd_almost", 32'(rd_almost), e.almost);
                check("rd_level",  32'(rd_level),  e.level);
            end
        end
    endtask

    // One clock: drive both sides, check acks, score, then compare after the edge.
    task automatic cycle(input logic wreq, input int wrb, input logic rreq, input int rrb);
        exp_t ew, er;
        wr_req   = wreq;
        wr_rgray = PW'(g(wrb));
        rd_req   = rreq;
        rd_rgray = PW'(g(rrb));
        #1;
        check("wr_ack", 32'(wr_ack), 32'(wreq && m_flag[0] == 0));
        check("rd_ack", 32'(rd_ack), 32'(rreq && m_flag[1] == 0));
        model_step(0, wreq, wrb, ew);
        sb_q.push_back(ew);
        model_step(1, rreq, rrb, er);
        sb_q.push_back(er);
        @(posedge clk);
        #1;
        compare_side(0);
        compare_side(1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wr_bin"},    32'(wr_bin),    32'd0);
        check({tag, "_wr_gray"},   32'(wr_gray),   32'd0);
        check({tag, "_wr_level"},  32'(wr_level),  32'd0);
        check({tag, "_wr_flag"},   32'(wr_flag),   32'd0);
        check({tag, "_wr_almost"}, 32'(wr_almost), 32'd0);
        check({tag, "_rd_bin"},    32'(rd_bin),    32'd0);
        check({tag, "_rd_level"},  32'(rd_level),  32'd0);
        check({tag, "_rd_flag"},   32'(rd_flag),   32'd1);
        check({tag, "_rd_almost"}, 32'(rd_almost), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gtab [8];
        int prev_gray;
        int wrapped;
        gtab = '{1, 3, 2, 6, 7, 5, 4, 12};

        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_rgray = '0; rd_rgray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;

        // Fill the write side against a stalled reader.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 0, 1'b0, 0);
            check("t1_gray",  32'(wr_gray),  gtab[i]);
            check("t1_level", 32'(wr_level), i + 1);
        end
        check("t1_full", 32'(wr_flag), 32'd1);
        cycle(1'b1, 0, 1'b0, 0);
        check("t1_bin_hold", 32'(wr_bin), 32'd8);

        // Reader frees one entry: full drops on the third edge, one more push refills.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1, 1'b0, 0);
        check("t2_flag",  32'(wr_flag),  32'd0);
        check("t2_level", 32'(wr_level), 32'd7);
        cycle(1'b1, 1, 1'b0, 0);
        check("t2_refull", 32'(wr_flag), 32'd1);
        check("t2_bin",    32'(wr_bin),  32'd9);

        // Read side sees four entries written, then drains them.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1, 1'b0, 4);
        check("t3_flag",   32'(rd_flag),   32'd0);
        check("t3_level",  32'(rd_level),  32'd4);
        check("t3_almost", 32'(rd_almost), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t3_addr", 32'(rd_addr), i);
            cycle(1'b0, 1, 1'b1, 4);
        end
        check("t3_empty", 32'(rd_flag), 32'd1);
        check("t3_bin",   32'(rd_bin),  32'd4);

        // Write side with the reader trailing by one, across the pointer wrap.
        for (int i = 0; i < 3; i++) cycle(1'b0, (m_bin[0] - 1) & PMASK, 1'b0, 4);
        prev_gray = int'(wr_gray);
        wrapped   = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, (m_bin[0] - 1) & PMASK, 1'b0, 4);
            check("t4_gray_step", 32'($countones(wr_gray ^ PW'(prev_gray))), 32'd1);
            check("t4_not_full",  32'(wr_flag), 32'd0);
            if (i >= 3) check("t4_level_steady", 32'(wr_level), 32'd4);
            if (m_bin[0] == 0) begin
                check("t4_wrap_gray", 32'(wr_gray), 32'd0);
                check("t4_wrap_addr", 32'(wr_addr), 32'd0);
                wrapped = 1;
            end
            prev_gray = int'(wr_gray);
        end
        check("t4_wrapped", 32'(wrapped), 32'd1);

        // Read side: level 1, then pop in the cycle the remote advance lands.
        for (int i = 0; i < 3; i++) cycle(1'b0, (m_bin[0] - 1) & PMASK, 1'b0, 5);
        check("t5_pre_level", 32'(rd_level), 32'd1);
        for (int i = 0; i < 2; i++) cycle(1'b0, (m_bin[0] - 1) & PMASK, 1'b0, 6);
        cycle(1'b0, (m_bin[0] - 1) & PMASK, 1'b1, 6);
        check("t5_level", 32'(rd_level), 32'd1);
        check("t5_flag",  32'(rd_flag),  32'd0);
        check("t5_bin",   32'(rd_bin),   32'd5);

        // Asynchronous reset between edges with five entries in flight.
        for (int i = 0; i < 3; i++) cycle(1'b0, (m_bin[0] - 5) & PMASK, 1'b0, 6);
        check("t6_pre_level", 32'(wr_level), 32'd5);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("t6");
        wr_rgray = '0;
        rd_rgray = '0;
        #2;
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 0, 1'b0, 0);
        check("t6_restart_bin",  32'(wr_bin),  32'd1);
        check("t6_restart_gray", 32'(wr_gray), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
